// File: rtl/axil_pkg.sv
// ---------------------------------------------------------------------------
// axil_pkg
// Shared definitions for the AXI4-Lite register master.
//   - AXI response encodings (OKAY / EXOKAY / SLVERR / DECERR)
//   - state_t : master FSM states
//   - is_aligned() : word-alignment test on the two low byte-address bits
// ---------------------------------------------------------------------------
package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WRESP,
        RD,
        RDATA,
        RSP
    } state_t;

    // A register access is word aligned when the two byte-offset bits are zero.
    function automatic logic is_aligned(input logic [1:0] lowBits);
        return (lowBits == 2'b00);
    endfunction

endpackage

// File: rtl/axil_reg_master.sv
// ---------------------------------------------------------------------------
// axil_reg_master
// Single-outstanding AXI4-Lite master. Converts a valid/ready command (read or
// write of one 32-bit register) into one AXI-Lite transaction and returns the
// read data / write status on a valid/ready response port. Every VALID and its
// payload are registered and held until the matching READY.
//
// Parameters
//   ADDR_W : AXI byte-address width
//   DATA_W : AXI data width (strobe width DATA_W/8)
//
// Ports
//   M_AXI_ACLK / M_AXI_ARESETN : clock, asynchronous active-low reset
//   cmd_*  : command request (valid/ready, write flag, addr, wdata, wstrb)
//   rsp_*  : response (valid/ready, write flag, rdata, resp)
//   M_AXI_AW*, W*, B*, AR*, R* : AXI4-Lite master channels, PROT tied to 0
//
// Build option
//   AXIL_MASTER_ALIGN_CHECK_EN : when defined, a command whose address is not
//   word aligned is never issued on AXI; it is answered one cycle after accept
//   with SLVERR and zero data. When undefined, the low address bits are passed
//   through unchanged.
// ---------------------------------------------------------------------------
module axil_reg_master
    import axil_pkg::*;
#(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
) (
    input  logic                  M_AXI_ACLK,
    input  logic                  M_AXI_ARESETN,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [DATA_W-1:0]     cmd_wdata,
    input  logic [DATA_W/8-1:0]   cmd_wstrb,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_write,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic [1:0]            rsp_resp,

    output logic                  M_AXI_AWVALID,
    input  logic                  M_AXI_AWREADY,
    output logic [ADDR_W-1:0]     M_AXI_AWADDR,
    output logic [2:0]            M_AXI_AWPROT,

    output logic                  M_AXI_WVALID,
    input  logic                  M_AXI_WREADY,
    output logic [DATA_W-1:0]     M_AXI_WDATA,
    output logic [DATA_W/8-1:0]   M_AXI_WSTRB,

    input  logic                  M_AXI_BVALID,
    output logic                  M_AXI_BREADY,
    input  logic [1:0]            M_AXI_BRESP,

    output logic                  M_AXI_ARVALID,
    input  logic                  M_AXI_ARREADY,
    output logic [ADDR_W-1:0]     M_AXI_ARADDR,
    output logic [2:0]            M_AXI_ARPROT,

    input  logic                  M_AXI_RVALID,
    output logic                  M_AXI_RREADY,
    input  logic [DATA_W-1:0]     M_AXI_RDATA,
    input  logic [1:0]            M_AXI_RRESP
);

    state_t                state_q, state_d;

    logic                  awValid_q, awValid_d;
    logic                  wValid_q,  wValid_d;
    logic                  arValid_q, arValid_d;

    logic [ADDR_W-1:0]     addr_q,    addr_d;
    logic [DATA_W-1:0]     wData_q,   wData_d;
    logic [DATA_W/8-1:0]   wStrb_q,   wStrb_d;
    logic                  isWrite_q, isWrite_d;
    logic [DATA_W-1:0]     rData_q,   rData_d;
    logic [1:0]            resp_q,    resp_d;

    logic                  cmdAccept;
    logic                  cmdMisaligned;
    logic                  awHs, wHs, arHs;
    logic                  awDone, wDone;

`ifdef AXIL_MASTER_ALIGN_CHECK_EN
    assign cmdMisaligned = !is_aligned(cmd_addr[1:0]);
`else
    assign cmdMisaligned = 1'b0;
`endif

    assign cmdAccept = (state_q == IDLE) && cmd_valid;

    assign awHs = awValid_q && M_AXI_AWREADY;
    assign wHs  = wValid_q  && M_AXI_WREADY;
    assign arHs = arValid_q && M_AXI_ARREADY;

    // A write channel is finished once its VALID has already dropped (handshake
    // in an earlier cycle) or it is handshaking right now; AW and W may complete
    // in either order or together.
    assign awDone = !awValid_q || awHs;
    assign wDone  = !wValid_q  || wHs;

    // State register. Reset forces IDLE, which abandons any transaction in flight.
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. A misaligned command (only possible with the alignment
    // check built in) skips the AXI phases and goes straight to the response.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmdMisaligned) begin
                        state_d = RSP;
                    end else if (cmd_write) begin
                        state_d = WR;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            WR: begin
                if (awDone && wDone) begin
                    state_d = WRESP;
                end
            end
            WRESP: begin
                if (M_AXI_BVALID) begin
                    state_d = RSP;
                end
            end
            RD: begin
                if (arHs) begin
                    state_d = RDATA;
                end
            end
            RDATA: begin
                if (M_AXI_RVALID) begin
                    state_d = RSP;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State-decoded outputs. BREADY/RREADY are only high while the matching
    // response is expected, so stray BVALID/RVALID in other states is ignored.
    always_comb begin
        cmd_ready    = (state_q == IDLE);
        M_AXI_BREADY = (state_q == WRESP);
        M_AXI_RREADY = (state_q == RDATA);
        rsp_valid    = (state_q == RSP);
    end

    // VALID next-state: raised in the cycle after the command is accepted and
    // each one dropped only after its own handshake.
    always_comb begin
        awValid_d = awValid_q;
        wValid_d  = wValid_q;
        arValid_d = arValid_q;
        if (cmdAccept && !cmdMisaligned) begin
            awValid_d = cmd_write;
            wValid_d  = cmd_write;
            arValid_d = !cmd_write;
        end
        if (awHs) begin
            awValid_d = 1'b0;
        end
        if (wHs) begin
            wValid_d = 1'b0;
        end
        if (arHs) begin
            arValid_d = 1'b0;
        end
    end

    // Payload and response next-state. The command is latched on accept; the
    // response fields are overwritten by B or R, and read data stays zero for
    // writes and for rejected misaligned commands.
    always_comb begin
        addr_d    = addr_q;
        wData_d   = wData_q;
        wStrb_d   = wStrb_q;
        isWrite_d = isWrite_q;
        rData_d   = rData_q;
        resp_d    = resp_q;
        if (cmdAccept) begin
            addr_d    = cmd_addr;
            wData_d   = cmd_wdata;
            wStrb_d   = cmd_wstrb;
            isWrite_d = cmd_write;
            rData_d   = '0;
            resp_d    = cmdMisaligned ? RESP_SLVERR : RESP_OKAY;
        end
        if ((state_q == WRESP) && M_AXI_BVALID) begin
            rData_d = '0;
            resp_d  = M_AXI_BRESP;
        end
        if ((state_q == RDATA) && M_AXI_RVALID) begin
            rData_d = M_AXI_RDATA;
            resp_d  = M_AXI_RRESP;
        end
    end

    // VALID and payload registers. The asynchronous reset clears every VALID
    // immediately, independent of the clock.
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            awValid_q <= 1'b0;
            wValid_q  <= 1'b0;
            arValid_q <= 1'b0;
            addr_q    <= '0;
            wData_q   <= '0;
            wStrb_q   <= '0;
            isWrite_q <= 1'b0;
            rData_q   <= '0;
            resp_q    <= RESP_OKAY;
        end else begin
            awValid_q <= awValid_d;
            wValid_q  <= wValid_d;
            arValid_q <= arValid_d;
            addr_q    <= addr_d;
            wData_q   <= wData_d;
            wStrb_q   <= wStrb_d;
            isWrite_q <= isWrite_d;
            rData_q   <= rData_d;
            resp_q    <= resp_d;
        end
    end

    assign M_AXI_AWVALID = awValid_q;
    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_WVALID  = wValid_q;
    assign M_AXI_WDATA   = wData_q;
    assign M_AXI_WSTRB   = wStrb_q;
    assign M_AXI_ARVALID = arValid_q;
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_ARPROT  = 3'b000;

    assign rsp_write = isWrite_q;
    assign rsp_rdata = rData_q;
    assign rsp_resp  = resp_q;

endmodule

// File: tb/tb_axil_reg_master.sv
// ---------------------------------------------------------------------------
// tb_axil_reg_master
// Bench for axil_reg_master with a behavioural 32-register AXI-Lite slave,
// a channel-stability monitor and a response scoreboard.
// Honours AXIL_MASTER_ALIGN_CHECK_EN for the misaligned-read case.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_axil_reg_master;
    import axil_pkg::*;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 32;
    localparam int STRB_W = DATA_W / 8;

    logic              clock = 1'b0;
    logic              rstN  = 1'b0;

    logic              cmdValid, cmdReady, cmdWrite;
    logic [ADDR_W-1:0] cmdAddr;
    logic [DATA_W-1:0] cmdWdata;
    logic [STRB_W-1:0] cmdWstrb;
    logic              rspValid, rspReady, rspWrite;
    logic [DATA_W-1:0] rspRdata;
    logic [1:0]        rspResp;

    logic              awValid, awReady, wValid, wReady, bValid, bReady;
    logic              arValid, arReady, rValid, rReady;
    logic [ADDR_W-1:0] awAddr, arAddr;
    logic [2:0]        awProt, arProt;
    logic [DATA_W-1:0] wData, rData;
    logic [STRB_W-1:0] wStrb;
    logic [1:0]        bResp, rResp;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    axil_reg_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .M_AXI_ACLK(clock), .M_AXI_ARESETN(rstN),
        .cmd_valid(cmdValid), .cmd_ready(cmdReady), .cmd_write(cmdWrite),
        .cmd_addr(cmdAddr), .cmd_wdata(cmdWdata), .cmd_wstrb(cmdWstrb),
        .rsp_valid(rspValid), .rsp_ready(rspReady), .rsp_write(rspWrite),
        .rsp_rdata(rspRdata), .rsp_resp(rspResp),
        .M_AXI_AWVALID(awValid), .M_AXI_AWREADY(awReady), .M_AXI_AWADDR(awAddr), .M_AXI_AWPROT(awProt),
        .M_AXI_WVALID(wValid), .M_AXI_WREADY(wReady), .M_AXI_WDATA(wData), .M_AXI_WSTRB(wStrb),
        .M_AXI_BVALID(bValid), .M_AXI_BREADY(bReady), .M_AXI_BRESP(bResp),
        .M_AXI_ARVALID(arValid), .M_AXI_ARREADY(arReady), .M_AXI_ARADDR(arAddr), .M_AXI_ARPROT(arProt),
        .M_AXI_RVALID(rValid), .M_AXI_RREADY(rReady), .M_AXI_RDATA(rData), .M_AXI_RRESP(rResp)
    );

    // Comparison helper shared by every check in the bench.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural slave ----------------
    // slvMode 0: readies always high, 1: random readies, 2: readies held low.
    // Address 0x78 answers writes with DECERR (no update) and reads with
    // SLVERR plus a marker word, so the master's response capture is visible.
    int                slvMode = 0;
    logic              forceB  = 1'b0;
    logic              bValidQ, awGot, wGot;
    logic [ADDR_W-1:0] awHeld;
    logic [DATA_W-1:0] wHeld;
    logic [STRB_W-1:0] sHeld;
    logic [DATA_W-1:0] slvMem [32];

    assign bValid = bValidQ | forceB;

    always @(posedge clock or negedge rstN) begin : slaveModel
        logic              hsAw, hsW, haveAw, haveW;
        logic [ADDR_W-1:0] wa;
        logic [DATA_W-1:0] wd;
        logic [STRB_W-1:0] ws;
        if (!rstN) begin
            awReady <= 1'b0; wReady <= 1'b0; arReady <= 1'b0;
            bValidQ <= 1'b0; bResp <= RESP_OKAY;
            rValid  <= 1'b0; rData <= '0; rResp <= RESP_OKAY;
            awGot   <= 1'b0; wGot <= 1'b0;
            awHeld  <= '0; wHeld <= '0; sHeld <= '0;
            for (int i = 0; i < 32; i++) slvMem[i] <= '0;
        end else begin
            awReady <= (slvMode == 0) ? 1'b1 : (slvMode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            wReady  <= (slvMode == 0) ? 1'b1 : (slvMode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            arReady <= (slvMode == 0) ? 1'b1 : (slvMode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            hsAw   = awValid && awReady;
            hsW    = wValid && wReady;
            haveAw = awGot || hsAw;
            haveW  = wGot || hsW;
            wa = awGot ? awHeld : awAddr;
            wd = wGot ? wHeld : wData;
            ws = wGot ? sHeld : wStrb;
            if (bValidQ && bReady) bValidQ <= 1'b0;
            if (haveAw && haveW && !bValidQ) begin
                if (wa == 7'h78) begin
                    bResp <= RESP_DECERR;
                end else begin
                    bResp <= RESP_OKAY;
                    for (int b = 0; b < STRB_W; b++)
                        if (ws[b]) slvMem[wa[6:2]][8*b +: 8] <= wd[8*b +: 8];
                end
                bValidQ <= 1'b1;
                awGot   <= 1'b0;
                wGot    <= 1'b0;
            end else begin
                awGot <= haveAw;
                wGot  <= haveW;
                if (hsAw) awHeld <= awAddr;
                if (hsW) begin
                    wHeld <= wData;
                    sHeld <= wStrb;
                end
            end
            if (rValid && rReady) rValid <= 1'b0;
            if (arValid && arReady && !rValid) begin
                rValid <= 1'b1;
                if (arAddr == 7'h78) begin
                    rData <= 32'hBAD0_BAD0;
                    rResp <= RESP_SLVERR;
                end else begin
                    rData <= slvMem[arAddr[6:2]];
                    rResp <= RESP_OKAY;
                end
            end
        end
    end

    // ---------------- channel stability monitor ----------------
    // A VALID seen without READY must still be high, with the same payload,
    // at the next sample point (reset excepted).
    logic              awPend = 1'b0, wPend = 1'b0, arPend = 1'b0;
    logic [ADDR_W-1:0] awPendAddr, arPendAddr;
    logic [DATA_W-1:0] wPendData;
    logic [STRB_W-1:0] wPendStrb;

    always @(negedge clock) begin
        if (!rstN) begin
            awPend = 1'b0; wPend = 1'b0; arPend = 1'b0;
        end else begin
            if (awPend) checkOutput("aw_hold", {awValid, 24'h0, awAddr}, {1'b1, 24'h0, awPendAddr});
            if (wPend)  checkOutput("w_hold_valid", {31'h0, wValid}, 32'h1);
            if (wPend)  checkOutput("w_hold_data", wData ^ {28'h0, wStrb}, wPendData ^ {28'h0, wPendStrb});
            if (arPend) checkOutput("ar_hold", {arValid, 24'h0, arAddr}, {1'b1, 24'h0, arPendAddr});
            awPend = awValid && !awReady; awPendAddr = awAddr;
            wPend  = wValid && !wReady;   wPendData = wData; wPendStrb = wStrb;
            arPend = arValid && !arReady; arPendAddr = arAddr;
        end
    end

    // ---------------- response scoreboard ----------------
    typedef struct {
        logic        write;
        logic [31:0] rdata;
        logic [1:0]  resp;
    } rsp_t;

    rsp_t expQ[$];
    rsp_t gotExp;

    always @(negedge clock) begin
        if (rstN && rspValid && rspReady) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_rsp", 32'h1, 32'h0);
            end else begin
                gotExp = expQ.pop_front();
                checkOutput("rsp_write", {31'h0, rspWrite}, {31'h0, gotExp.write});
                checkOutput("rsp_rdata", rspRdata, gotExp.rdata);
                checkOutput("rsp_resp", {30'h0, rspResp}, {30'h0, gotExp.resp});
            end
        end
    end

    // ---------------- stimulus ----------------
    typedef struct {
        logic        write;
        logic [6:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          hold;
        bit          rnd;
        logic [31:0] expRdata;
        logic [1:0]  expResp;
    } vec_t;

    vec_t vecs[14];

    // Drive one command and return once it has been accepted.
    task automatic driveCmd(input logic wr, input logic [6:0] a, input logic [31:0] wd, input logic [3:0] ws);
        int n;
        cmdValid = 1'b1; cmdWrite = wr; cmdAddr = a; cmdWdata = wd; cmdWstrb = ws;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!cmdReady && n < 50);
        checkOutput("cmd_accept_timeout", {31'h0, cmdReady}, 32'h1);
        @(posedge clock); #1;
        cmdValid = 1'b0;
    endtask

    // Wait for the scoreboard to consume every pending response.
    task automatic waitDrain();
        int n;
        n = 0;
        while (expQ.size() != 0 && n < 200) begin
            @(negedge clock);
            n++;
        end
        checkOutput("rsp_drain_timeout", expQ.size(), 32'h0);
        expQ.delete();
        @(posedge clock); #1;
    endtask

    task automatic applyStimulus(input vec_t v);
        int n;
        slvMode  = v.rnd ? 1 : 0;
        rspReady = (v.hold == 0);
        driveCmd(v.write, v.addr, v.wdata, v.wstrb);
        expQ.push_back('{v.write, v.expRdata, v.expResp});
        if (v.hold > 0) begin
            n = 0;
            do begin
                @(negedge clock);
                n++;
            end while (!rspValid && n < 100);
            for (int i = 0; i < v.hold; i++) begin
                if (i > 0) @(negedge clock);
                checkOutput("hold_rsp_valid", {31'h0, rspValid}, 32'h1);
                checkOutput("hold_cmd_ready", {31'h0, cmdReady}, 32'h0);
                checkOutput("hold_rdata", rspRdata, v.expRdata);
            end
            @(posedge clock); #1;
            rspReady = 1'b1;
        end
        waitDrain();
    endtask

    // Zero-wait transaction with accept-to-rsp_valid latency measurement.
    task automatic issueAndTime(input logic wr, input logic [6:0] a, input logic [31:0] wd,
                                input logic [3:0] ws, input logic [31:0] expRd, input logic [1:0] expRs,
                                input int expLat, input string tag, output logic sawAr);
        int n;
        slvMode = 0; rspReady = 1'b1; sawAr = 1'b0;
        driveCmd(wr, a, wd, ws);
        expQ.push_back('{wr, expRd, expRs});
        n = 0;
        do begin
            @(negedge clock);
            n++;
            sawAr |= arValid;
        end while (!rspValid && n < 20);
        checkOutput({tag, "_latency"}, n, expLat);
        waitDrain();
    endtask

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] simulation timeout");
    end

    initial begin : mainSeq
        logic sawAr;
        logic seenRsp;
        cmdValid = 1'b0; cmdWrite = 1'b0; cmdAddr = '0; cmdWdata = '0; cmdWstrb = '0;
        rspReady = 1'b1;

        vecs[0]  = '{1'b1, 7'h40, 32'h8000_0000, 4'b1000, 0, 1'b0, 32'h0, RESP_OKAY};
        vecs[1]  = '{1'b0, 7'h40, 32'h0,         4'b0000, 0, 1'b0, 32'h8000_0000, RESP_OKAY};
        vecs[2]  = '{1'b1, 7'h44, 32'h1234_5678, 4'b1111, 5, 1'b0, 32'h0, RESP_OKAY};
        vecs[3]  = '{1'b0, 7'h44, 32'h0,         4'b0000, 0, 1'b0, 32'h1234_5678, RESP_OKAY};
        vecs[4]  = '{1'b1, 7'h44, 32'hAABB_CCDD, 4'b0101, 0, 1'b1, 32'h0, RESP_OKAY};
        vecs[5]  = '{1'b0, 7'h44, 32'h0,         4'b0000, 0, 1'b1, 32'h12BB_56DD, RESP_OKAY};
        vecs[6]  = '{1'b1, 7'h7C, 32'hDEAD_BEEF, 4'b1111, 0, 1'b1, 32'h0, RESP_OKAY};
        vecs[7]  = '{1'b0, 7'h7C, 32'h0,         4'b0000, 0, 1'b1, 32'hDEAD_BEEF, RESP_OKAY};
        vecs[8]  = '{1'b0, 7'h00, 32'h0,         4'b0000, 0, 1'b0, 32'h0, RESP_OKAY};
        vecs[9]  = '{1'b1, 7'h00, 32'hFFFF_FFFF, 4'b0000, 0, 1'b1, 32'h0, RESP_OKAY};
        vecs[10] = '{1'b0, 7'h00, 32'h0,         4'b0000, 0, 1'b1, 32'h0, RESP_OKAY};
        vecs[11] = '{1'b0, 7'h40, 32'h0,         4'b0000, 2, 1'b1, 32'h8000_0000, RESP_OKAY};
        vecs[12] = '{1'b1, 7'h78, 32'h0000_0001, 4'b1111, 0, 1'b0, 32'h0, RESP_DECERR};
        vecs[13] = '{1'b0, 7'h78, 32'h0,         4'b0000, 3, 1'b0, 32'hBAD0_BAD0, RESP_SLVERR};

        // Reset held two cycles with the command port idle.
        repeat (2) @(posedge clock);
        @(negedge clock);
        checkOutput("rst_awvalid", {31'h0, awValid}, 32'h0);
        checkOutput("rst_wvalid", {31'h0, wValid}, 32'h0);
        checkOutput("rst_arvalid", {31'h0, arValid}, 32'h0);
        checkOutput("rst_readies", {30'h0, bReady, rReady}, 32'h0);
        checkOutput("rst_cmd_ready", {31'h0, cmdReady}, 32'h1);
        checkOutput("rst_rsp_valid", {31'h0, rspValid}, 32'h0);
        @(posedge clock); #1;
        rstN = 1'b1;
        repeat (2) @(posedge clock);
        #1;

        for (int i = 0; i < 14; i++) applyStimulus(vecs[i]);

        issueAndTime(1'b1, 7'h48, 32'h0000_00A5, 4'b0001, 32'h0, RESP_OKAY, 3, "lat_wr", sawAr);
        issueAndTime(1'b0, 7'h48, 32'h0, 4'b0000, 32'h0000_00A5, RESP_OKAY, 3, "lat_rd", sawAr);

        // Stray BVALID while idle must be ignored.
        forceB = 1'b1;
        repeat (2) begin
            @(negedge clock);
            checkOutput("stray_b_bready", {31'h0, bReady}, 32'h0);
            checkOutput("stray_b_rsp_valid", {31'h0, rspValid}, 32'h0);
        end
        @(posedge clock); #1;
        forceB = 1'b0;

        // Reset while a write is stalled in WR: VALIDs drop at once, no response.
        slvMode = 2;
        @(posedge clock); #1;
        driveCmd(1'b1, 7'h50, 32'h5555_AAAA, 4'b1111);
        @(negedge clock);
        checkOutput("pre_rst_aw_w_valid", {30'h0, awValid, wValid}, 32'h3);
        #2 rstN = 1'b0;
        #1;
        checkOutput("mid_rst_awvalid", {31'h0, awValid}, 32'h0);
        checkOutput("mid_rst_wvalid", {31'h0, wValid}, 32'h0);
        repeat (2) @(negedge clock);
        @(posedge clock); #1;
        rstN = 1'b1;
        slvMode = 0;
        seenRsp = 1'b0;
        repeat (6) begin
            @(negedge clock);
            seenRsp |= rspValid;
        end
        checkOutput("post_rst_no_rsp", {31'h0, seenRsp}, 32'h0);
        @(posedge clock); #1;

        // Fresh traffic after reset: slave registers are back to zero.
        applyStimulus('{1'b0, 7'h40, 32'h0, 4'b0000, 0, 1'b0, 32'h0, RESP_OKAY});
        applyStimulus('{1'b1, 7'h40, 32'h0BAD_F00D, 4'b1111, 0, 1'b0, 32'h0, RESP_OKAY});

`ifdef AXIL_MASTER_ALIGN_CHECK_EN
        issueAndTime(1'b0, 7'h42, 32'h0, 4'b0000, 32'h0, RESP_SLVERR, 1, "misalign_rd", sawAr);
        checkOutput("misalign_no_arvalid", {31'h0, sawAr}, 32'h0);
`else
        issueAndTime(1'b0, 7'h42, 32'h0, 4'b0000, 32'h0BAD_F00D, RESP_OKAY, 3, "misalign_rd", sawAr);
        checkOutput("misalign_arvalid", {31'h0, sawAr}, 32'h1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
